gyro_err_demod: RTL and testbench



---
 rtl/gyro_demod_pkg.sv | 16 +
 rtl/demod_window_gen.sv | 140 ++++++++++++++
 rtl/gyro_err_demod.sv | 149 ++++++++++++++
 tb/tb_gyro_err_demod.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gyro_demod_pkg.sv
// Shared definitions for the gyro error demodulator.
// Holds the FSM state encoding, the default widths, and the minimum half-period length.
package gyro_demod_pkg;

  localparam int ADC_BIT_DEF = 14;
  localparam int AVG_MAX_DEF = 15;
  localparam int ACC_W       = ADC_BIT_DEF + AVG_MAX_DEF + 1;
  localparam int FREQ_MIN    = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HIGH = 3'd1,
    ST_LOW  = 3'd2
  } state_t;

endpackage

// File: rtl/demod_window_gen.sv
// Modulation timing for the gyro error demodulator.
// Runs the IDLE/HIGH/LOW half-period FSM and the half-period counter, and drives the
// registered modulation bit. It latches the period parameters at each HIGH entry.
// Flags it decodes:
//   in_window  - the counter is inside the post-settling accumulation window
//   last_cycle - final clock of the current half
//   enter_*    - the next clock starts a new half
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_en                      run enable (0 forces IDLE)
//   i_freq/i_wait_cnt         half-period length / settling skip, latched at HIGH entry
//   i_avg_sel/i_polarity      window log2 length / error sign, latched at HIGH entry
//   o_state                   current FSM state
//   o_mod                     modulation bit, 1 during HIGH
//   o_in_window, o_last_cycle decoded counter flags for the current clock
//   o_enter_high, o_enter_low next clock begins a HIGH / LOW half
//   o_avg_sel_l, o_polarity_l latched parameters of the running period
module demod_window_gen
  import gyro_demod_pkg::*;
#(
  parameter int AVG_MAX = AVG_MAX_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [31:0] i_freq,
  input  logic [31:0] i_wait_cnt,
  input  logic [3:0]  i_avg_sel,
  input  logic        i_polarity,
  output state_t      o_state,
  output logic        o_mod,
  output logic        o_in_window,
  output logic        o_last_cycle,
  output logic        o_enter_high,
  output logic        o_enter_low,
  output logic [3:0]  o_avg_sel_l,
  output logic        o_polarity_l
);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mod_q, mod_d;
  logic [31:0] freq_l_q, freq_l_d;
  logic [31:0] wait_l_q, wait_l_d;
  logic [3:0]  avg_l_q, avg_l_d;
  logic        pol_l_q, pol_l_d;
  logic        latch;
  logic        last;
  logic [32:0] win_end;

  // Window end is computed one bit wider so a huge settling count cannot wrap.
  assign win_end = {1'b0, wait_l_q} + (33'd1 << avg_l_q);
  assign last    = (state_q != ST_IDLE) && (cnt_q == freq_l_q - 32'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          latch   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (last) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_LOW: begin
        // Back-to-back periods: relatch parameters on the same edge that re-enters HIGH.
        if (last) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          latch   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      latch   = 1'b0;
    end

    freq_l_d = freq_l_q;
    wait_l_d = wait_l_q;
    avg_l_d  = avg_l_q;
    pol_l_d  = pol_l_q;
    if (latch) begin
      freq_l_d = (i_freq < 32'(FREQ_MIN)) ? 32'(FREQ_MIN) : i_freq;
      wait_l_d = i_wait_cnt;
      avg_l_d  = (i_avg_sel > 4'(AVG_MAX)) ? 4'(AVG_MAX) : i_avg_sel;
      pol_l_d  = i_polarity;
    end

    mod_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mod_q    <= 1'b0;
      freq_l_q <= 32'(FREQ_MIN);
      wait_l_q <= '0;
      avg_l_q  <= '0;
      pol_l_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mod_q    <= mod_d;
      freq_l_q <= freq_l_d;
      wait_l_q <= wait_l_d;
      avg_l_q  <= avg_l_d;
      pol_l_q  <= pol_l_d;
    end
  end

  assign o_state      = state_q;
  assign o_mod        = mod_q;
  assign o_last_cycle = last;
  assign o_in_window  = (state_q != ST_IDLE) && (cnt_q >= wait_l_q) &&
                        ({1'b0, cnt_q} < win_end);
  assign o_enter_high = (state_d == ST_HIGH) && (state_q != ST_HIGH);
  assign o_enter_low  = (state_d == ST_LOW) && (state_q != ST_LOW);
  assign o_avg_sel_l  = avg_l_q;
  assign o_polarity_l = pol_l_q;

endmodule

// File: rtl/gyro_err_demod.sv
// Closed-loop gyro error demodulator.
// Generates the square-wave bias modulation. It sums ADC samples inside each half's
// settling-skipped window. Once per modulation period it emits
// (sum_high - sum_low) >>> avg_sel, optionally negated, minus an offset, together
// with a one-clock valid strobe.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           demodulation enable
//   i_adc          signed ADC sample
//   i_freq         half-period length in clocks (values below 2 act as 2)
//   i_wait_cnt     settling clocks skipped at the start of each half
//   i_avg_sel      log2 of the accumulation window length
//   i_polarity     1 negates the error
//   i_err_offset   signed offset subtracted from the error at compute time
//   o_mod          modulation bit (1 = high half)
//   o_err          signed error, held between updates
//   o_err_valid    one-clock strobe per completed period
//   o_cstate       FSM state for debug
module gyro_err_demod
  import gyro_demod_pkg::*;
#(
  parameter int ADC_BIT = ADC_BIT_DEF,
  parameter int AVG_MAX = AVG_MAX_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic signed [ADC_BIT-1:0] i_adc,
  input  logic [31:0]               i_freq,
  input  logic [31:0]               i_wait_cnt,
  input  logic [3:0]                i_avg_sel,
  input  logic                      i_polarity,
  input  logic signed [31:0]        i_err_offset,
  output logic                      o_mod,
  output logic signed [31:0]        o_err,
  output logic                      o_err_valid,
  output logic [2:0]                o_cstate
);

  localparam int ACC_WID = ADC_BIT + AVG_MAX + 1;

  state_t     win_state;
  logic       in_window, last_cycle, enter_high, enter_low, pol_l;
  logic [3:0] avg_l;

  demod_window_gen #(
    .AVG_MAX (AVG_MAX)
  ) u_win (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_freq       (i_freq),
    .i_wait_cnt   (i_wait_cnt),
    .i_avg_sel    (i_avg_sel),
    .i_polarity   (i_polarity),
    .o_state      (win_state),
    .o_mod        (o_mod),
    .o_in_window  (in_window),
    .o_last_cycle (last_cycle),
    .o_enter_high (enter_high),
    .o_enter_low  (enter_low),
    .o_avg_sel_l  (avg_l),
    .o_polarity_l (pol_l)
  );

  // Sign-extend (or wrap) an accumulator-width value into the 32-bit error word.
  function automatic logic signed [31:0] to_err32(input logic signed [ACC_WID-1:0] x);
    logic signed [ACC_WID+31:0] wide;
    wide = {{32{x[ACC_WID-1]}}, x};
    return wide[31:0];
  endfunction

  logic signed [ACC_WID-1:0] adc_ext;
  logic signed [ACC_WID-1:0] acc_h_q, acc_h_d, acc_l_q, acc_l_d;
  logic signed [ACC_WID-1:0] snap_h_q, snap_h_d, snap_l_q, snap_l_d;
  logic [3:0]                snap_avg_q, snap_avg_d;
  logic                      snap_pol_q, snap_pol_d;
  logic                      compute_q, compute_d;
  logic signed [31:0]        err_q, err_d;
  logic                      err_vld_q, err_vld_d;
  logic                      take;
  logic signed [ACC_WID-1:0] diff, shifted;
  logic signed [31:0]        e;

  assign adc_ext = {{(ACC_WID-ADC_BIT){i_adc[ADC_BIT-1]}}, i_adc};
  assign take    = (win_state == ST_LOW) && last_cycle && i_en;

  always_comb begin
    // Accumulate stage: per-half window sums
    acc_h_d = acc_h_q;
    acc_l_d = acc_l_q;
    if ((win_state == ST_HIGH) && in_window) acc_h_d = acc_h_q + adc_ext;
    if ((win_state == ST_LOW) && in_window)  acc_l_d = acc_l_q + adc_ext;
    if (enter_high || !i_en) acc_h_d = '0;
    if (enter_low || !i_en)  acc_l_d = '0;

    // Snapshot stage: the final LOW sample is folded in directly, and the averaging
    // shift and polarity are kept with the sums because the live copies are
    // relatched for the next period on this same edge.
    snap_h_d   = snap_h_q;
    snap_l_d   = snap_l_q;
    snap_avg_d = snap_avg_q;
    snap_pol_d = snap_pol_q;
    compute_d  = take;
    if (take) begin
      snap_h_d   = acc_h_q;
      snap_l_d   = in_window ? (acc_l_q + adc_ext) : acc_l_q;
      snap_avg_d = avg_l;
      snap_pol_d = pol_l;
    end

    // Compute stage: difference, average, sign, offset
    diff    = snap_h_q - snap_l_q;
    shifted = diff >>> snap_avg_q;
    e       = to_err32(shifted);
    if (snap_pol_q) e = -e;
    err_d     = compute_q ? (e - i_err_offset) : err_q;
    err_vld_d = compute_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_h_q    <= '0;
      acc_l_q    <= '0;
      snap_h_q   <= '0;
      snap_l_q   <= '0;
      snap_avg_q <= '0;
      snap_pol_q <= 1'b0;
      compute_q  <= 1'b0;
      err_q      <= '0;
      err_vld_q  <= 1'b0;
    end else begin
      acc_h_q    <= acc_h_d;
      acc_l_q    <= acc_l_d;
      snap_h_q   <= snap_h_d;
      snap_l_q   <= snap_l_d;
      snap_avg_q <= snap_avg_d;
      snap_pol_q <= snap_pol_d;
      compute_q  <= compute_d;
      err_q      <= err_d;
      err_vld_q  <= err_vld_d;
    end
  end

  assign o_err       = err_q;
  assign o_err_valid = err_vld_q;
  assign o_cstate    = win_state;

endmodule

// File: tb/tb_gyro_err_demod.sv
module tb_gyro_err_demod;

  logic               clk = 1'b0;
  logic               rst, en, pol;
  logic signed [13:0] adc;
  logic [31:0]        freq, wait_c;
  logic [3:0]         avg;
  logic signed [31:0] off;
  logic               mod, vld;
  logic signed [31:0] err;
  logic [2:0]         cstate;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_v    = 0;
  int lo_v    = 0;

  always #5 clk = ~clk;

  gyro_err_demod dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_adc        (adc),
    .i_freq       (freq),
    .i_wait_cnt   (wait_c),
    .i_avg_sel    (avg),
    .i_polarity   (pol),
    .i_err_offset (off),
    .o_mod        (mod),
    .o_err        (err),
    .o_err_valid  (vld),
    .o_cstate     (cstate)
  );

  typedef struct {
    int freq;
    int wait_c;
    int avg;
    int pol;
    int off;
    int hi;
    int lo;
    int exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
    adc = mod ? 14'(hi_v) : 14'(lo_v);
  endtask

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (vld) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int fl, nv, first, second, n, cnt;
    logic signed [31:0] e1, e2;

    rst = 1'b0; en = 1'b0; pol = 1'b0; adc = '0;
    freq = 32'd8; wait_c = 32'd2; avg = 4'd2; off = '0;

    vecs[0] = '{freq: 8, wait_c: 2, avg: 2, pol: 0, off: 0,  hi: 100,  lo: -100, exp_err: 200};
    vecs[1] = '{freq: 8, wait_c: 2, avg: 2, pol: 1, off: 50, hi: 100,  lo: -100, exp_err: -250};
    vecs[2] = '{freq: 8, wait_c: 2, avg: 2, pol: 1, off: 50, hi: 100,  lo: 100,  exp_err: -50};
    vecs[3] = '{freq: 4, wait_c: 2, avg: 2, pol: 0, off: 0,  hi: 100,  lo: -100, exp_err: 100};
    vecs[4] = '{freq: 0, wait_c: 0, avg: 0, pol: 0, off: 0,  hi: 100,  lo: -100, exp_err: 200};
    vecs[5] = '{freq: 4, wait_c: 1, avg: 2, pol: 0, off: 0,  hi: -3,   lo: 0,    exp_err: -3};
    vecs[6] = '{freq: 8, wait_c: 2, avg: 2, pol: 0, off: 32'h8000_0000,
                hi: 100, lo: -100, exp_err: 32'h8000_00C8};

    // Reset state
    do_reset();
    chk("rst_mod", mod, 0);
    chk("rst_err", err, 0);
    chk("rst_vld", vld, 0);
    chk("rst_cstate", cstate, 0);

    // Table-driven periods: latency, value, interval, strobe count
    for (int v = 0; v < 7; v++) begin
      do_reset();
      freq = vecs[v].freq; wait_c = vecs[v].wait_c; avg = 4'(vecs[v].avg);
      pol = vecs[v].pol[0]; off = vecs[v].off;
      hi_v = vecs[v].hi; lo_v = vecs[v].lo;
      fl = (vecs[v].freq < 2) ? 2 : vecs[v].freq;
      en = 1'b1;
      nv = 0; first = -1; second = -1; e1 = '0; e2 = '0;
      for (int k = 1; k <= 4*fl + 3; k++) begin
        step();
        if (k == 1)      chk($sformatf("v%0d_mod_high", v), mod, 1);
        if (k == 1 + fl) chk($sformatf("v%0d_mod_low", v), mod, 0);
        if (vld) begin
          nv++;
          if (nv == 1) begin first = k; e1 = err; end
          else if (nv == 2) begin second = k; e2 = err; end
        end
      end
      chk($sformatf("v%0d_latency", v), first, 2*fl + 2);
      chk($sformatf("v%0d_err1", v), e1, vecs[v].exp_err);
      chk($sformatf("v%0d_interval", v), second - first, 2*fl);
      chk($sformatf("v%0d_err2", v), e2, vecs[v].exp_err);
      chk($sformatf("v%0d_nstrobe", v), nv, 2);
    end

    // Mid-period abort during LOW of period 3, then re-enable
    do_reset();
    freq = 8; wait_c = 2; avg = 2; pol = 0; off = 0; hi_v = 100; lo_v = -100;
    en = 1'b1;
    wait_strobe(40, n);
    chk("abort_p1_lat", n, 18);
    chk("abort_p1_err", err, 200);
    off = 30;
    wait_strobe(20, n);
    chk("abort_p2_int", n, 16);
    chk("abort_p2_err", err, 170);
    for (int i = 0; i < 7; i++) step();
    chk("abort_in_low", cstate, 2);
    for (int i = 0; i < 3; i++) step();
    en = 1'b0; off = 999;
    step();
    chk("abort_mod", mod, 0);
    chk("abort_cstate", cstate, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vld) cnt++;
    end
    chk("abort_no_strobe", cnt, 0);
    chk("abort_err_hold", err, 170);
    en = 1'b1;
    wait_strobe(40, n);
    chk("reen_lat", n, 18);
    chk("reen_err", err, -799);

    // Enable falling on the snapshot cycle discards the period
    for (int i = 0; i < 14; i++) step();
    chk("snapdrop_in_low", cstate, 2);
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (vld) cnt++;
    end
    chk("snapdrop_no_strobe", cnt, 0);
    chk("snapdrop_err_hold", err, -799);
    chk("snapdrop_mod", mod, 0);

    // Reset mid-LOW, restart, and a mid-period frequency change
    off = 0; en = 1'b1;
    wait_strobe(40, n);
    chk("rstlow_p1_lat", n, 18);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstlow_mod", mod, 0);
    chk("rstlow_err", err, 0);
    chk("rstlow_vld", vld, 0);
    chk("rstlow_cstate", cstate, 0);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 3) freq = 4;
      if (vld) begin
        n = i;
        break;
      end
    end
    chk("restart_lat", n, 18);
    chk("restart_err", err, 200);
    wait_strobe(20, n);
    chk("newfreq_int", n, 8);
    chk("newfreq_err", err, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
